// File: rtl/vga_pkg.sv
// Shared geometry defaults, pattern mode encodings and colour type for the
// VGA pattern generator.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned BAR_W_DEF    = 80;
  localparam int unsigned POS_W        = 10;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle: upstream timing and pattern controls in, delayed syncs
// and colour out.
interface vga_pattern_gen_if;
  import vga_pkg::*;

  logic             hsync_in;
  logic             vsync_in;
  logic             display_on;
  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;
  logic [1:0]       mode;
  logic             scroll_en;

  logic             VGA_HS;
  logic             VGA_VS;
  logic [3:0]       VGA_R;
  logic [3:0]       VGA_G;
  logic [3:0]       VGA_B;
  logic             frame_start;

  modport master (
    output hsync_in, vsync_in, display_on, hpos, vpos, mode, scroll_en,
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, frame_start
  );

  modport slave (
    input  hsync_in, vsync_in, display_on, hpos, vpos, mode, scroll_en,
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, frame_start
  );

endinterface

// File: rtl/vga_pattern_color.sv
// Combinational pattern decoder: latched mode plus pixel coordinates to RGB.
module vga_pattern_color
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BAR_W    = BAR_W_DEF
) (
  input  mode_e            mode_i,
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] hpos_i,
  input  logic [POS_W-1:0] vpos_i,
  output rgb_t             rgb_o
);

  localparam logic [POS_W-1:0] HLast = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] VLast = POS_W'(V_ACTIVE - 1);

  logic [2:0] idx;
  logic [2:0] bar;
  logic       grid_hit;

  // Bar index by threshold counting; avoids a divider.
  always_comb begin
    idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x_i) >= i * BAR_W) idx = idx + 3'd1;
    end
  end

  assign bar      = 3'd7 - idx;
  assign grid_hit = (hpos_i[5:0] == 6'd0) || (vpos_i[5:0] == 6'd0) ||
                    (hpos_i == HLast) || (vpos_i == VLast);

  always_comb begin
    rgb_o = '0;
    case (mode_i)
      MODE_BARS:  rgb_o = '{r: {4{bar[2]}}, g: {4{bar[1]}}, b: {4{bar[0]}}};
      MODE_CHECK: if (hpos_i[5] ^ vpos_i[5]) rgb_o = '{r: 4'hF, g: 4'hF, b: 4'hF};
      MODE_RAMP:  rgb_o = '{r: hpos_i[9:6], g: hpos_i[9:6], b: hpos_i[9:6]};
      MODE_GRID:  if (grid_hit) rgb_o = '{r: 4'hF, g: 4'hF, b: 4'hF};
      default:    rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage test-pattern pipeline: stage 1 samples timing and scrolled x,
// stage 2 registers blanked colour. Mode/scroll are frame-latched.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BAR_W    = BAR_W_DEF
) (
  input logic            clk,
  input logic            reset_n,
  vga_pattern_gen_if.slave bus
);

  localparam logic [POS_W-1:0] HLast = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W:0]   HSpan = (POS_W + 1)'(H_ACTIVE);

  logic             frame_evt;
  mode_e            mode_q, mode_d;
  logic             scroll_q, scroll_d;
  logic [POS_W-1:0] offset_q, offset_d;
  logic [POS_W:0]   sum;
  logic [POS_W-1:0] x_d;

  logic             hs1_q, vs1_q, de1_q, fs1_q;
  mode_e            mode1_q;
  logic [POS_W-1:0] x1_q, hpos1_q, vpos1_q;

  logic             hs2_q, vs2_q, fs2_q;
  rgb_t             rgb_pat, rgb_d, rgb2_q;

  assign frame_evt = bus.display_on && (bus.hpos == '0) && (bus.vpos == '0);

  // The frame-start pixel itself already uses the freshly latched mode/offset.
  always_comb begin
    mode_d   = mode_q;
    scroll_d = scroll_q;
    offset_d = offset_q;
    if (frame_evt) begin
      mode_d   = mode_e'(bus.mode);
      scroll_d = bus.scroll_en;
      if (scroll_q) offset_d = (offset_q == HLast) ? '0 : offset_q + 1'b1;
    end
  end

  assign sum = {1'b0, bus.hpos} + {1'b0, offset_d};
  assign x_d = POS_W'((sum >= HSpan) ? sum - HSpan : sum);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_BARS;
      scroll_q <= 1'b0;
      offset_q <= '0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      de1_q    <= 1'b0;
      fs1_q    <= 1'b0;
      mode1_q  <= MODE_BARS;
      x1_q     <= '0;
      hpos1_q  <= '0;
      vpos1_q  <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      fs2_q    <= 1'b0;
      rgb2_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      scroll_q <= scroll_d;
      offset_q <= offset_d;
      hs1_q    <= bus.hsync_in;
      vs1_q    <= bus.vsync_in;
      de1_q    <= bus.display_on;
      fs1_q    <= frame_evt;
      mode1_q  <= mode_d;
      x1_q     <= x_d;
      hpos1_q  <= bus.hpos;
      vpos1_q  <= bus.vpos;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      fs2_q    <= fs1_q;
      rgb2_q   <= rgb_d;
    end
  end

  vga_pattern_color #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BAR_W    (BAR_W)
  ) u_color (
    .mode_i (mode1_q),
    .x_i    (x1_q),
    .hpos_i (hpos1_q),
    .vpos_i (vpos1_q),
    .rgb_o  (rgb_pat)
  );

  assign rgb_d = de1_q ? rgb_pat : '0;

  assign bus.VGA_HS      = hs2_q;
  assign bus.VGA_VS      = vs2_q;
  assign bus.VGA_R       = rgb2_q.r;
  assign bus.VGA_G       = rgb2_q.g;
  assign bus.VGA_B       = rgb2_q.b;
  assign bus.frame_start = fs2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench: each driven pixel queues its expected output, a negedge
// monitor compares it two clocks later.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  vga_pattern_gen_if bus();

  vga_pattern_gen #(
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .BAR_W    (80)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    bit          ck;
    bit          hs;
    bit          vs;
    bit          fs;
    logic [11:0] rgb;
    int          h;
    int          v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        if (e.ck) begin
          check($sformatf("rgb(%0d,%0d)", e.h, e.v),
                int'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), int'(e.rgb));
          check($sformatf("hs(%0d,%0d)", e.h, e.v), int'(bus.VGA_HS), int'(e.hs));
          check($sformatf("vs(%0d,%0d)", e.h, e.v), int'(bus.VGA_VS), int'(e.vs));
          check($sformatf("fs(%0d,%0d)", e.h, e.v), int'(bus.frame_start), int'(e.fs));
        end
      end
    end
  end

  task automatic px(input bit hs, input bit vs, input bit de, input int h, input int v,
                    input int m, input bit se, input bit ck, input logic [11:0] rgb,
                    input bit fs);
    exp_t e;
    @(posedge clk);
    #1;
    bus.hsync_in   = hs;
    bus.vsync_in   = vs;
    bus.display_on = de;
    bus.hpos       = 10'(h);
    bus.vpos       = 10'(v);
    bus.mode       = 2'(m);
    bus.scroll_en  = se;
    e.due = cyc + 2;
    e.ck  = ck;
    e.hs  = hs;
    e.vs  = vs;
    e.fs  = fs;
    e.rgb = rgb;
    e.h   = h;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic pix(input int h, input int v, input int m, input bit se,
                     input logic [11:0] rgb, input bit fs);
    px(1'b0, 1'b0, 1'b1, h, v, m, se, 1'b1, rgb, fs);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rgb"}, int'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 0);
    check({tag, "_hs"}, int'(bus.VGA_HS), 0);
    check({tag, "_vs"}, int'(bus.VGA_VS), 0);
    check({tag, "_fs"}, int'(bus.frame_start), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hsync_in   = 1'b0;
    bus.vsync_in   = 1'b0;
    bus.display_on = 1'b0;
    bus.hpos       = '0;
    bus.vpos       = '0;
    bus.mode       = '0;
    bus.scroll_en  = 1'b0;
    reset_n        = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Bars, no scroll; frame_start lasts one clock
    pix(0, 0, 0, 0, 12'hFFF, 1'b1);
    pix(1, 0, 0, 0, 12'hFFF, 1'b0);
    pix(0, 10, 0, 0, 12'hFFF, 1'b0);
    pix(79, 10, 0, 0, 12'hFFF, 1'b0);
    pix(80, 10, 0, 0, 12'hFF0, 1'b0);
    pix(160, 10, 0, 0, 12'hF0F, 1'b0);
    pix(639, 10, 0, 0, 12'h000, 1'b0);

    // Blanking with sync toggles
    px(1'b1, 1'b0, 1'b0, 100, 10, 0, 1'b0, 1'b1, 12'h000, 1'b0);
    px(1'b0, 1'b1, 1'b0, 100, 10, 0, 1'b0, 1'b1, 12'h000, 1'b0);
    px(1'b1, 1'b1, 1'b0, 100, 10, 0, 1'b0, 1'b1, 12'h000, 1'b0);
    px(1'b0, 1'b0, 1'b0, 100, 10, 0, 1'b0, 1'b1, 12'h000, 1'b0);

    // Ramp
    pix(0, 0, 2, 0, 12'h000, 1'b1);
    pix(320, 0, 2, 0, 12'h555, 1'b0);
    pix(639, 0, 2, 0, 12'h999, 1'b0);

    // Checker
    pix(0, 0, 1, 0, 12'h000, 1'b1);
    pix(32, 0, 1, 0, 12'hFFF, 1'b0);
    pix(32, 32, 1, 0, 12'h000, 1'b0);
    pix(0, 32, 1, 0, 12'hFFF, 1'b0);

    // Mid-frame mode change only takes effect at next frame start
    pix(0, 0, 0, 0, 12'hFFF, 1'b1);
    pix(300, 5, 3, 0, 12'hF00, 1'b0);
    pix(301, 5, 3, 0, 12'hF00, 1'b0);
    pix(0, 0, 3, 0, 12'hFFF, 1'b1);
    pix(64, 5, 3, 0, 12'hFFF, 1'b0);
    pix(65, 5, 3, 0, 12'h000, 1'b0);
    pix(639, 5, 3, 0, 12'hFFF, 1'b0);
    pix(65, 479, 3, 0, 12'hFFF, 1'b0);
    pix(65, 6, 0, 0, 12'h000, 1'b0);

    // Scroll: three frames with scroll_en, offset reaches 3 in frame 4
    pix(0, 0, 0, 1, 12'hFFF, 1'b1);
    pix(0, 0, 0, 1, 12'hFFF, 1'b1);
    pix(0, 0, 0, 1, 12'hFFF, 1'b1);
    pix(0, 0, 0, 0, 12'hFFF, 1'b1);
    pix(76, 10, 0, 0, 12'hFFF, 1'b0);
    pix(77, 10, 0, 0, 12'hFF0, 1'b0);
    pix(0, 0, 0, 0, 12'hFFF, 1'b1);
    pix(77, 10, 0, 0, 12'hFF0, 1'b0);

    // Advance offset from 3 to 639 with single-pixel frames
    for (int k = 0; k <= 636; k++) begin
      px(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 12'h000, 1'b1);
    end
    pix(0, 10, 0, 0, 12'h000, 1'b0);
    pix(1, 10, 0, 0, 12'hFFF, 1'b0);
    pix(80, 10, 0, 0, 12'hFFF, 1'b0);
    pix(81, 10, 0, 0, 12'hFF0, 1'b0);
    pix(0, 0, 0, 0, 12'hFFF, 1'b1);
    pix(79, 10, 0, 0, 12'hFFF, 1'b0);
    pix(80, 10, 0, 0, 12'hFF0, 1'b0);

    // Build nonzero offset and mode 2, then reset mid-line
    pix(0, 0, 0, 1, 12'hFFF, 1'b1);
    pix(0, 0, 2, 1, 12'h000, 1'b1);
    px(1'b1, 1'b1, 1'b1, 400, 3, 2, 1'b1, 1'b1, 12'h666, 1'b0);
    @(posedge clk);
    #1;
    bus.hsync_in   = 1'b0;
    bus.vsync_in   = 1'b0;
    bus.display_on = 1'b0;
    drain();
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Latched mode back to bars, offset back to 0
    pix(80, 10, 3, 0, 12'hFF0, 1'b0);
    pix(79, 10, 3, 0, 12'hFFF, 1'b0);
    pix(0, 0, 0, 0, 12'hFFF, 1'b1);
    pix(79, 10, 0, 0, 12'hFFF, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter BAR_W, default 80: colour-bar width in pixels; H_ACTIVE SHALL be 8*BAR_W.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  pixel clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 hsync_in, vsync_in  in  1 each  sync from upstream timing generator.
REQ-008 display_on  in  1  high inside the active area.
REQ-009 hpos, vpos  in  10 each  current pixel position, aligned with the syncs.
REQ-010 mode  in  2  pattern select: 0 bars, 1 checker, 2 ramp, 3 grid.
REQ-011 scroll_en  in  1  enables horizontal bar scrolling.
REQ-012 VGA_HS, VGA_VS  out  1 each  delayed syncs.
REQ-013 VGA_R, VGA_G, VGA_B  out  4 each  pixel colour.
REQ-014 frame_start  out  1  one-cycle pulse, aligned with outputs, at pixel (0,0).

Function
REQ-015 Two-stage pipeline: stage 1 registers inputs and computes pattern coordinates; stage 2 registers colour; all outputs SHALL lag inputs by exactly 2 clocks.
REQ-016 Syncs and display_on SHALL pass through the same 2-stage delay, unmodified in polarity.
REQ-017 When delayed display_on is 0, VGA_R/G/B SHALL be 4'h0 regardless of mode.
REQ-018 Frame-start event: input hpos==0 and vpos==0 and display_on==1; frame_start SHALL pulse 2 clocks later.
REQ-019 mode and scroll_en SHALL be sampled only at the frame-start event; changes mid-frame take effect next frame.
REQ-020 Scroll offset: 10-bit register; at each frame-start event with latched scroll_en=1, offset SHALL increment by 1, wrapping H_ACTIVE-1 to 0; with scroll_en=0 it holds.
REQ-021 Mode 0: x = (hpos + offset) mod H_ACTIVE (no 11-bit overflow; subtract H_ACTIVE when sum >= H_ACTIVE); idx = x / BAR_W (0..7), computed by comparison or counter, no divider; b = 7 - idx; R = {4{b[2]}}, G = {4{b[1]}}, B = {4{b[0]}}.
REQ-022 Mode 1: all channels 4'hF when hpos[5] XOR vpos[5] = 1, else 4'h0; offset not applied.
REQ-023 Mode 2: all channels = hpos[9:6] (0..9 across 640 pixels).
REQ-024 Mode 3: all channels 4'hF when hpos[5:0]==0, vpos[5:0]==0, hpos==H_ACTIVE-1 or vpos==V_ACTIVE-1; else 4'h0.
REQ-025 Inputs outside the active area are not decoded; only blanking (REQ-017) applies.

Reset
REQ-026 On reset_n low, asynchronously: pipeline registers cleared, VGA_HS=VGA_VS=0, RGB=4'h0, frame_start=0, offset=0, latched mode=0, latched scroll_en=0.
REQ-027 After reset release the first valid output SHALL appear 2 clocks after the first sampled input; reset mid-frame SHALL abandon the frame with no partial state retained.

Structure
REQ-028 H_ACTIVE, V_ACTIVE, BAR_W defaults and the mode encodings (MODE_BARS=0, MODE_CHECK=1, MODE_RAMP=2, MODE_GRID=3) SHALL live in a shared package vga_pkg.
REQ-029 Colour computation SHALL be one sub-module, vga_pattern_color (combinational, mode + coordinates -> RGB); pipeline, latching and offset stay in the top.

Verification
REQ-030 Mode 0, scroll_en=0, hpos=0/79/80/639 on line 10 -> RGB 2 clocks later = FFF/FFF/FF0/000.
REQ-031 Mode 0, scroll_en=1 for 3 frames -> frame 4 pixel hpos=77 shows FF0 (x=80); offset reaches 3; offset 639 wraps to 0 next frame.
REQ-032 Mode switched 0->3 at hpos=300 mid-frame -> rest of frame stays bars; next frame pixel (64,5) = FFF, (65,5) = 000.
REQ-033 display_on=0 with hpos=100, mode 0 -> RGB=000; HS/VS toggles reproduced exactly 2 clocks later.
REQ-034 Input (0,0) display_on=1 -> frame_start high for exactly one clock, 2 clocks later; mode 2 pixel hpos=639 -> RGB=999.
REQ-035 reset_n asserted mid-line asynchronously -> outputs 0 immediately without clock edge; offset=0 after release.
